// File: rtl/imm_decode_stage_ctrl_pkg.sv
// Shared types for the ID-stage immediate controller.
// Opcode map, select encoding, FSM states and the ID/EX payload.
package imm_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    IMM_I = 3'b000,
    IMM_R = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_U = 3'b100,
    IMM_J = 3'b101
  } imm_sel_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } stage_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_sel_e        sel;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_RST = '{
    imm:     '0,
    sel:     IMM_R,
    pc:      '0,
    rd:      '0,
    illegal: 1'b0
  };

endpackage

// File: rtl/imm_decode_stage_ctrl_if.sv
// IF/ID input and ID/EX output handshake bundle.
// slave = the stage, master = surrounding pipeline.
interface imm_decode_stage_ctrl_if;
  import imm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_instr;
  logic [XLEN-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [SEL_W-1:0]  out_imm_sel;
  logic [XLEN-1:0]   out_pc;
  logic [4:0]        out_rd;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_imm, out_imm_sel,
    output out_pc, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_imm, out_imm_sel,
    input  out_pc, out_rd, out_illegal
  );

endinterface

// File: rtl/imm_decode_stage_ctrl_immediate_extend.sv
// RV32 immediate extraction and sign extension.
// Selects outside the I/S/B/U/J set yield zero.
module immediate_extend
  import imm_pkg::*;
(
  input  logic [XLEN-1:0] imm_value,
  input  imm_sel_e        imm_select,
  output logic [XLEN-1:0] imm_out
);

  logic [XLEN-1:0] v;
  logic            unused;

  assign v      = imm_value;
  assign unused = &{1'b0, v[6:0]};

  always_comb begin
    imm_out = '0;
    case (imm_select)
      IMM_I: imm_out = {{20{v[31]}}, v[31:20]};
      IMM_S: imm_out = {{20{v[31]}}, v[31:25], v[11:7]};
      IMM_B: imm_out = {{19{v[31]}}, v[31], v[7],
                        v[30:25], v[11:8], 1'b0};
      IMM_U: imm_out = {v[31:12], 12'b0};
      IMM_J: imm_out = {{11{v[31]}}, v[31], v[19:12],
                        v[20], v[30:21], 1'b0};
      default: imm_out = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage_ctrl.sv
// ID-stage immediate decode with a 1-entry skid buffer and flush.
// Optional IMM_ILLEGAL_TRAP_EN flags unmapped opcodes via out_illegal.
module imm_decode_stage_ctrl
  import imm_pkg::*;
(
  input logic                    clk,
  input logic                    reset_n,
  imm_decode_stage_ctrl_if.slave bus
);

  logic [6:0]      opcode;
  imm_sel_e        dec_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] ext_imm;
  id_ex_t          dec_entry;
  id_ex_t          out_q;
  id_ex_t          skid_q;
  stage_e          state_q;
  stage_e          state_d;
  logic            accept;
  logic            transfer;
  logic            load_out;
  logic            load_skid;
  logic            move_skid;

  assign opcode = bus.in_instr[6:0];

  always_comb begin
    dec_sel = IMM_R;
    unique case (1'b1)
      (opcode == OP_IMM) ||
      (opcode == OP_LOAD) ||
      (opcode == OP_JALR):   dec_sel = IMM_I;
      (opcode == OP_REG):    dec_sel = IMM_R;
      (opcode == OP_STORE):  dec_sel = IMM_S;
      (opcode == OP_BRANCH): dec_sel = IMM_B;
      (opcode == OP_LUI) ||
      (opcode == OP_AUIPC):  dec_sel = IMM_U;
      (opcode == OP_JAL):    dec_sel = IMM_J;
      default:               dec_sel = IMM_R;
    endcase
  end

`ifdef IMM_ILLEGAL_TRAP_EN
  assign dec_illegal = ((dec_sel == IMM_R) && (opcode != OP_REG))
                     || (bus.in_instr[1:0] != 2'b11);
`else
  assign dec_illegal = 1'b0;
`endif

  immediate_extend u_ext (
    .imm_value  (bus.in_instr),
    .imm_select (dec_sel),
    .imm_out    (ext_imm)
  );

  assign dec_entry = '{
    imm:     dec_illegal ? '0 : ext_imm,
    sel:     dec_illegal ? IMM_R : dec_sel,
    pc:      bus.in_pc,
    rd:      bus.in_instr[11:7],
    illegal: dec_illegal
  };

  assign bus.in_ready  = (state_q != SKID);
  assign bus.out_valid = (state_q != EMPTY);

  assign accept   = bus.in_valid & bus.in_ready;
  assign transfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = FULL;
            load_out = 1'b1;
          end
        end
        FULL: begin
          if (accept && !transfer) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end else if (accept) begin
            load_out = 1'b1;
          end else if (transfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (transfer) begin
            state_d   = FULL;
            move_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Payload only moves on accept or skid drain; it holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= ID_EX_RST;
      skid_q <= ID_EX_RST;
    end else begin
      if (load_out)       out_q <= dec_entry;
      else if (move_skid) out_q <= skid_q;
      if (load_skid)      skid_q <= dec_entry;
    end
  end

  assign bus.out_imm     = out_q.imm;
  assign bus.out_imm_sel = out_q.sel;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage_ctrl.sv
// Randomised bench for imm_decode_stage_ctrl against a queue model.
// Honours IMM_ILLEGAL_TRAP_EN for the expected out_illegal.
module tb_imm_decode_stage_ctrl;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  imm_decode_stage_ctrl_if bus ();

  imm_decode_stage_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    int   v;
    int   s;
    s = ins[31] ? 1 : 0;
    v = 0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: e.sel = 3'd0;
      7'h33:               e.sel = 3'd1;
      7'h23:               e.sel = 3'd2;
      7'h63:               e.sel = 3'd3;
      7'h37, 7'h17:        e.sel = 3'd4;
      7'h6F:               e.sel = 3'd5;
      default:             e.sel = 3'd1;
    endcase
    case (e.sel)
      3'd0: v = int'(ins[30:20]) - s * 2048;
      3'd2: v = int'(ins[30:25]) * 32 + int'(ins[11:7]) - s * 2048;
      3'd3: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2 - s * 4096;
      3'd4: v = int'(ins[31:12]) * 4096;
      3'd5: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
              + int'(ins[30:21]) * 2 - s * (1 << 20);
      default: v = 0;
    endcase
    e.imm = v;
    e.pc  = pc;
    e.rd  = ins[11:7];
`ifdef IMM_ILLEGAL_TRAP_EN
    e.ill = (e.sel == 3'd1) && (ins[6:0] != 7'h33);
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc,
                       logic rdy, logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic check_outs();
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("imm", bus.out_imm, q[0].imm);
      chk("sel", bus.out_imm_sel, q[0].sel);
      chk("pc", bus.out_pc, q[0].pc);
      chk("rd", bus.out_rd, q[0].rd);
      chk("illegal", bus.out_illegal, q[0].ill);
    end
  endtask

  task automatic step();
    bit acc;
    bit xfr;
    @(posedge clk);
    acc = bus.in_valid && (q.size() < 2);
    xfr = bus.out_ready && (q.size() > 0);
    if (bus.flush) begin
      q.delete();
    end else begin
      if (xfr) void'(q.pop_front());
      if (acc) q.push_back(model(bus.in_instr, bus.in_pc));
    end
    #1;
    check_outs();
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_ready"}, bus.in_ready, 1);
    chk({tag, "_sel"}, bus.out_imm_sel, 3'b001);
    chk({tag, "_imm"}, bus.out_imm, 0);
    chk({tag, "_pc"}, bus.out_pc, 0);
    chk({tag, "_rd"}, bus.out_rd, 0);
    chk({tag, "_ill"}, bus.out_illegal, 0);
  endtask

  logic [6:0] ops [9] = '{7'h13, 7'h03, 7'h67, 7'h33, 7'h23,
                          7'h63, 7'h37, 7'h17, 7'h6F};

  initial begin
    logic [31:0] held;
    logic [31:0] ins;
    logic [6:0]  op;

    drive(0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // basic addi
    drive(1, 32'h00A00093, 32'h100, 1, 0);
    step();
    chk("addi_imm", bus.out_imm, 32'h0000000A);
    chk("addi_sel", bus.out_imm_sel, 3'b000);
    chk("addi_rd", bus.out_rd, 5'd1);

    // back-to-back stream
    drive(1, 32'h00112523, 32'h104, 1, 0);
    step();
    chk("sw_imm", bus.out_imm, 32'h0000000A);
    chk("sw_sel", bus.out_imm_sel, 3'b010);
    drive(1, 32'h123450B7, 32'h108, 1, 0);
    step();
    chk("lui_imm", bus.out_imm, 32'h12345000);
    chk("lui_sel", bus.out_imm_sel, 3'b100);
    drive(1, 32'hFFDFF06F, 32'h10C, 1, 0);
    step();
    chk("jal_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("jal_sel", bus.out_imm_sel, 3'b101);
    drive(0, 0, 0, 1, 0);
    step();

    // backpressure into skid
    drive(1, 32'h00A00093, 32'h200, 0, 0);
    step();
    held = bus.out_imm;
    drive(1, 32'h123450B7, 32'h204, 0, 0);
    step();
    chk("bp_in_ready", bus.in_ready, 0);
    drive(1, 32'hFFDFF06F, 32'h208, 0, 0);
    step();
    chk("bp_stable", bus.out_imm, 32'h0000000A);
    chk("bp_pc", bus.out_pc, 32'h200);
    drive(0, 0, 0, 1, 0);
    step();
    chk("drain_ready", bus.in_ready, 1);
    chk("drain_imm", bus.out_imm, 32'h12345000);
    step();

    // flush while in skid with a competing input
    drive(1, 32'h00112523, 32'h300, 0, 0);
    step();
    step();
    drive(1, 32'h00A00093, 32'h308, 0, 1);
    step();
    chk("flush_valid", bus.out_valid, 0);
    drive(0, 0, 0, 0, 0);
    step();

    // unmapped opcode
    drive(1, 32'h0000007F, 32'h400, 0, 0);
    step();
    chk("ill_sel", bus.out_imm_sel, 3'b001);
    chk("ill_imm", bus.out_imm, 0);
`ifdef IMM_ILLEGAL_TRAP_EN
    chk("ill_flag", bus.out_illegal, 1);
`else
    chk("ill_flag", bus.out_illegal, 0);
`endif
    drive(0, 0, 0, 1, 0);
    step();

    // asynchronous reset while in skid
    drive(1, 32'h00112523, 32'h500, 0, 0);
    step();
    step();
    chk("pre_rst_ready", bus.in_ready, 0);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    chk_reset_vals("mid_rst");
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(8)];
      ins = {25'($urandom), op};
      drive(($urandom_range(9) < 7), ins, $urandom,
            ($urandom_range(9) < 6), ($urandom_range(99) < 3));
      step();
    end
    held = held;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
